// File: rtl/atm_ctrl_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | atm_ctrl_param : parametrised ATM session controller (card..PIN..dispense)  |
// | Optional feature macro: DAILY_LIMIT_EN (cumulative withdrawal limit)       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module atm_ctrl_param #(
  parameter int               PIN_W       = 16,
  parameter logic [PIN_W-1:0] PIN_REF     = 'h1234,
  parameter int               AMT_W       = 16,
  parameter int               NUM_ACCT    = 2,
  parameter int               INIT_BAL    = 1000,
  parameter int               MAX_TRIES   = 3,
  parameter int               TIMEOUT_CYC = 255,
  parameter int               DAY_LIMIT   = 500,
  localparam int              ACCT_W      = (NUM_ACCT > 1) ? $clog2(NUM_ACCT) : 1,
  localparam int              CNT_W       = $clog2(MAX_TRIES + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              card_insert,
  input  logic              card_removed,
  input  logic              language,
  input  logic              lang_valid,
  input  logic [ACCT_W-1:0] type_of_account,
  input  logic              acct_valid,
  input  logic [PIN_W-1:0]  enter_pin,
  input  logic              pin_valid,
  input  logic [AMT_W-1:0]  enter_amount,
  input  logic              amt_valid,
  input  logic              cancel,
  input  logic              dispense_ack,
  input  logic              day_clr,
  output logic [3:0]        state,
  output logic [CNT_W-1:0]  count,
  output logic              lang_q,
  output logic              dispense_req,
  output logic [AMT_W-1:0]  dispense_amt,
  output logic              card_eject,
  output logic              card_retain,
  output logic              out,
  output logic [2:0]        err_code,
  output logic [AMT_W-1:0]  balance
);

  localparam int               TMR_W      = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMR_W-1:0] c_TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] c_TRY_LAST = CNT_W'(MAX_TRIES - 1);
  localparam logic [ACCT_W:0]  c_NACCT    = (ACCT_W + 1)'(NUM_ACCT);
  localparam logic [AMT_W-1:0] c_INIT_BAL = AMT_W'(INIT_BAL);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_LANG     = 4'd1,
    S_ACCT     = 4'd2,
    S_PIN      = 4'd3,
    S_AMOUNT   = 4'd4,
    S_CHECK    = 4'd5,
    S_DISPENSE = 4'd6,
    S_EJECT    = 4'd7,
    S_RETAIN   = 4'd8
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               lang_sel_q, lang_sel_d;
  logic [ACCT_W-1:0]  acct_q, acct_d;
  logic [AMT_W-1:0]   amt_q, amt_d;
  logic [2:0]         err_q, err_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [AMT_W-1:0]   bal_q [NUM_ACCT];
  logic [AMT_W-1:0]   bal_d [NUM_ACCT];
  logic               disp_req_q, eject_q, retain_q, out_q;
  logic [AMT_W-1:0]   disp_amt_q, balance_q;
  logic               dispensed;
  logic               active;
  logic               strobe;
  logic               timeout;

`ifdef DAILY_LIMIT_EN
  localparam logic [AMT_W:0] c_DAY_LIM = (AMT_W + 1)'(DAY_LIMIT);
  logic [AMT_W-1:0] daily_q, daily_d;
  logic [AMT_W:0]   day_sum;

  assign day_sum = {1'b0, daily_q} + {1'b0, amt_q};

  always_comb begin
    daily_d = daily_q;
    if (dispensed) daily_d = daily_q + amt_q;
    if (day_clr)   daily_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) daily_q <= '0;
    else       daily_q <= daily_d;
  end
`else
  logic unused_day_clr;
  assign unused_day_clr = day_clr;
`endif

  assign active  = (state_q == S_LANG) || (state_q == S_ACCT) ||
                   (state_q == S_PIN)  || (state_q == S_AMOUNT);
  assign strobe  = lang_valid | acct_valid | pin_valid | amt_valid;
  assign timeout = active && !strobe && (tmr_q == c_TMR_LAST);

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    lang_sel_d = lang_sel_q;
    acct_d     = acct_q;
    amt_d      = amt_q;
    err_d      = err_q;
    bal_d      = bal_q;
    dispensed  = 1'b0;
    // cancel outranks both the timeout and any strobe arriving the same cycle
    if (active && cancel) begin
      state_d = S_EJECT;
      err_d   = 3'd1;
    end else if (timeout) begin
      state_d = S_EJECT;
      err_d   = 3'd2;
    end else begin
      case (state_q)
        S_IDLE: if (card_insert) begin
          state_d = S_LANG;
          count_d = '0;
          err_d   = 3'd0;
        end
        S_LANG: if (lang_valid) begin
          lang_sel_d = language;
          state_d    = S_ACCT;
        end
        S_ACCT: if (acct_valid && ({1'b0, type_of_account} < c_NACCT)) begin
          acct_d  = type_of_account;
          state_d = S_PIN;
        end
        S_PIN: if (pin_valid) begin
          if (enter_pin == PIN_REF) begin
            state_d = S_AMOUNT;
          end else if (count_q == c_TRY_LAST) begin
            count_d = CNT_W'(MAX_TRIES);
            state_d = S_RETAIN;
            err_d   = 3'd5;
          end else begin
            count_d = count_q + CNT_W'(1);
          end
        end
        S_AMOUNT: if (amt_valid) begin
          amt_d   = enter_amount;
          state_d = S_CHECK;
        end
        S_CHECK: begin
          if (amt_q == '0) begin
            state_d = S_EJECT;
            err_d   = 3'd4;
          end else if (amt_q > bal_q[acct_q]) begin
            state_d = S_EJECT;
            err_d   = 3'd3;
          end
`ifdef DAILY_LIMIT_EN
          else if (day_sum > c_DAY_LIM) begin
            state_d = S_EJECT;
            err_d   = 3'd6;
          end
`endif
          else begin
            state_d = S_DISPENSE;
          end
        end
        S_DISPENSE: if (dispense_ack) begin
          bal_d[acct_q] = bal_q[acct_q] - amt_q;
          dispensed     = 1'b1;
          state_d       = S_EJECT;
          err_d         = 3'd0;
        end
        S_EJECT:  if (card_removed) state_d = S_IDLE;
        S_RETAIN: state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  // idle timer restarts on every strobe and on every state change
  always_comb begin
    tmr_d = tmr_q + TMR_W'(1);
    if (!active || strobe || (state_d != state_q)) tmr_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      lang_sel_q <= 1'b0;
      acct_q     <= '0;
      amt_q      <= '0;
      err_q      <= 3'd0;
      tmr_q      <= '0;
      for (int i = 0; i < NUM_ACCT; i++) bal_q[i] <= c_INIT_BAL;
      disp_req_q <= 1'b0;
      disp_amt_q <= '0;
      eject_q    <= 1'b0;
      retain_q   <= 1'b0;
      out_q      <= 1'b0;
      balance_q  <= c_INIT_BAL;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      lang_sel_q <= lang_sel_d;
      acct_q     <= acct_d;
      amt_q      <= amt_d;
      err_q      <= err_d;
      tmr_q      <= tmr_d;
      bal_q      <= bal_d;
      disp_req_q <= (state_d == S_DISPENSE);
      disp_amt_q <= (state_d == S_DISPENSE) ? amt_d : '0;
      eject_q    <= (state_d == S_EJECT);
      retain_q   <= (state_d == S_RETAIN);
      out_q      <= dispensed;
      balance_q  <= bal_d[acct_d];
    end
  end

  assign state        = state_q;
  assign count        = count_q;
  assign lang_q       = lang_sel_q;
  assign dispense_req = disp_req_q;
  assign dispense_amt = disp_amt_q;
  assign card_eject   = eject_q;
  assign card_retain  = retain_q;
  assign out          = out_q;
  assign err_code     = err_q;
  assign balance      = balance_q;

endmodule
`default_nettype wire

// File: tb/tb_atm_ctrl_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_atm_ctrl_param : directed self-checking bench for atm_ctrl_param         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_atm_ctrl_param;
  localparam int PIN_W  = 16;
  localparam int AMT_W  = 16;
  localparam int ACCT_W = 1;
  localparam int CNT_W  = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              card_insert = 1'b0, card_removed = 1'b0;
  logic              language = 1'b0, lang_valid = 1'b0;
  logic [ACCT_W-1:0] type_of_account = '0;
  logic              acct_valid = 1'b0;
  logic [PIN_W-1:0]  enter_pin = '0;
  logic              pin_valid = 1'b0;
  logic [AMT_W-1:0]  enter_amount = '0;
  logic              amt_valid = 1'b0;
  logic              cancel = 1'b0, dispense_ack = 1'b0, day_clr = 1'b0;
  logic [3:0]        state;
  logic [CNT_W-1:0]  count;
  logic              lang_q, dispense_req, card_eject, card_retain, out;
  logic [AMT_W-1:0]  dispense_amt, balance;
  logic [2:0]        err_code;

  atm_ctrl_param dut (
    .clk(clk), .reset(reset), .card_insert(card_insert), .card_removed(card_removed),
    .language(language), .lang_valid(lang_valid), .type_of_account(type_of_account),
    .acct_valid(acct_valid), .enter_pin(enter_pin), .pin_valid(pin_valid),
    .enter_amount(enter_amount), .amt_valid(amt_valid), .cancel(cancel),
    .dispense_ack(dispense_ack), .day_clr(day_clr), .state(state), .count(count),
    .lang_q(lang_q), .dispense_req(dispense_req), .dispense_amt(dispense_amt),
    .card_eject(card_eject), .card_retain(card_retain), .out(out),
    .err_code(err_code), .balance(balance)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [AMT_W-1:0] exp_q[$];
  int model_bal[2];
  int model_day;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    model_bal[0] = 1000;
    model_bal[1] = 1000;
    model_day    = 0;
  endtask

  // Waits for a dispense request, then pops the scoreboard and compares the amount.
  task automatic wait_req();
    int n;
    logic [AMT_W-1:0] e;
    n = 0;
    while (dispense_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("disp_req_seen", {31'd0, dispense_req}, 32'd1);
    chk("sb_has_entry", exp_q.size(), 32'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("disp_amt", dispense_amt, e);
    end
  endtask

  task automatic start_session(input int acct);
    card_insert = 1'b1; tick(); card_insert = 1'b0;
    chk("sess_state_lang", state, 32'd1);
    chk("sess_err_clr", err_code, 32'd0);
    chk("sess_count_clr", count, 32'd0);
    language = 1'b1; lang_valid = 1'b1; tick(); lang_valid = 1'b0;
    chk("sess_lang_q", lang_q, 32'd1);
    type_of_account = acct[0]; acct_valid = 1'b1; tick(); acct_valid = 1'b0;
    chk("sess_state_pin", state, 32'd3);
    chk("sess_balance", balance, model_bal[acct]);
  endtask

  task automatic remove_card();
    chk("eject_level", card_eject, 32'd1);
    card_removed = 1'b1; tick(); card_removed = 1'b0;
    chk("idle_after_remove", state, 32'd0);
    chk("eject_cleared", card_eject, 32'd0);
  endtask

  task automatic withdraw(input int acct, input int amt);
    int exp_err;
    start_session(acct);
    enter_pin = 16'h1234; pin_valid = 1'b1; tick(); pin_valid = 1'b0;
    chk("pin_ok_state", state, 32'd4);
    if (amt == 0)                    exp_err = 4;
    else if (amt > model_bal[acct])  exp_err = 3;
`ifdef DAILY_LIMIT_EN
    else if (model_day + amt > 500)  exp_err = 6;
`endif
    else                             exp_err = 0;
    if (exp_err == 0) exp_q.push_back(AMT_W'(amt));
    enter_amount = AMT_W'(amt); amt_valid = 1'b1; tick(); amt_valid = 1'b0;
    chk("check_state", state, 32'd5);
    tick();
    if (exp_err == 0) begin
      chk("dispense_state", state, 32'd6);
      wait_req();
      tick(); tick();
      chk("disp_amt_hold", dispense_amt, AMT_W'(amt));
      dispense_ack = 1'b1; tick(); dispense_ack = 1'b0;
      model_bal[acct] -= amt;
      model_day       += amt;
      chk("out_pulse", out, 32'd1);
      chk("req_dropped", dispense_req, 32'd0);
    end
    chk("post_state", state, 32'd7);
    chk("post_err", err_code, exp_err);
    chk("post_balance", balance, model_bal[acct]);
    tick();
    chk("out_one_cycle", out, 32'd0);
    remove_card();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    model_reset();
    tick(); tick();
    chk("rst_state", state, 32'd0);
    chk("rst_req", dispense_req, 32'd0);
    chk("rst_eject", card_eject, 32'd0);
    chk("rst_err", err_code, 32'd0);
    chk("rst_count", count, 32'd0);
    chk("rst_balance", balance, 32'd1000);
    reset = 1'b0;
    tick();

    // full flow and balance boundaries
    withdraw(0, 200);
    chk("bal_after_200", balance, 32'd800);
    withdraw(1, 1001);
    withdraw(1, 1000);
    chk("bal_zero", balance, 32'd0);
    withdraw(0, 0);

    // three wrong PINs retain the card
    start_session(0);
    for (int i = 1; i <= 3; i++) begin
      enter_pin = 16'h0000; pin_valid = 1'b1; tick(); pin_valid = 1'b0;
      chk("wrong_pin_count", count, i);
      chk("wrong_pin_state", state, (i == 3) ? 32'd8 : 32'd3);
    end
    chk("retain_pulse", card_retain, 32'd1);
    chk("retain_err", err_code, 32'd5);
    tick();
    chk("retain_idle", state, 32'd0);
    chk("retain_pulse_end", card_retain, 32'd0);
    chk("retain_err_held", err_code, 32'd5);

    // inactivity timeout in PIN
    start_session(0);
    repeat (254) tick();
    chk("tmo_not_yet", state, 32'd3);
    tick();
    chk("tmo_state", state, 32'd7);
    chk("tmo_err", err_code, 32'd2);
    remove_card();

    // cancel beats a same-cycle PIN strobe
    start_session(0);
    enter_pin = 16'h1234; pin_valid = 1'b1; cancel = 1'b1; tick();
    pin_valid = 1'b0; cancel = 1'b0;
    chk("cancel_state", state, 32'd7);
    chk("cancel_err", err_code, 32'd1);
    remove_card();

    // reset while dispensing drops the request and restores balances
    start_session(0);
    enter_pin = 16'h1234; pin_valid = 1'b1; tick(); pin_valid = 1'b0;
    exp_q.push_back(AMT_W'(100));
    enter_amount = AMT_W'(100); amt_valid = 1'b1; tick(); amt_valid = 1'b0;
    wait_req();
    reset = 1'b1; tick(); reset = 1'b0;
    model_reset();
    chk("mid_rst_state", state, 32'd0);
    chk("mid_rst_req", dispense_req, 32'd0);
    chk("mid_rst_balance", balance, 32'd1000);
    tick();

`ifdef DAILY_LIMIT_EN
    withdraw(0, 300);
    withdraw(0, 300);
    day_clr = 1'b1; tick(); day_clr = 1'b0;
    model_day = 0;
    withdraw(0, 300);
    chk("daily_bal", balance, 32'd400);
`endif

    chk("sb_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
